// File: rtl/pong_input_pkg.sv
// Shared encodings for the Pong button input path.
// State codes are plain 2-bit constants so legacy consumers can compare them directly.
package pong_input_pkg;

  localparam logic [1:0] ST_LOCKOUT = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_LONG    = 2'd3;

  localparam int PRESS_COUNT_W = 8;

endpackage

// File: rtl/button_event_gen_cycle_timer.sv
// cycle_timer: free-running up-counter with clear/enable and a terminal compare.
// done is a same-cycle pulse when an enabled count sits on terminal; the counter
// wraps itself to 0 on done so back-to-back periods need no extra clear.
module cycle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  assign done = enable && !clear && (count == terminal);

  // Count while enabled; reset, clear or terminal hit returns to zero.
  always_ff @(posedge clock) begin
    if (reset || clear || done) count <= '0;
    else if (enable)            count <= count + 1'b1;
  end

endmodule

// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into one-cycle game events
// (press, release, long press, auto-repeat), a held level and a wrapping press count.
// All outputs are registered: an event shows up the cycle after the edge that saw its cause.
// Optional feature macro: BTN_AUTOREPEAT_EN (repeat pulses while in LONG; when undefined,
// LONG is terminal until release with the timer frozen and repeat_pulse tied low).
import pong_input_pkg::*;

module button_event_gen #(
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int REPEAT_CYCLES     = 200,
  parameter int CNT_W             = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       level,
  output logic       press,
  output logic       release_pulse,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RP_TERM = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0]       state, state_nxt;
  logic             tmr_clr, tmr_en, tmr_done;
  logic [CNT_W-1:0] tmr_term;
  logic             press_nxt, rel_nxt, long_nxt, rep_nxt;

  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (tmr_clr),
    .enable   (tmr_en),
    .terminal (tmr_term),
    .done     (tmr_done)
  );

  // Next-state and event decode; a falling level is checked first so release
  // always wins over a long-press or repeat due on the same cycle.
  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    tmr_term  = LP_TERM;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    long_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    case (state)
      ST_LOCKOUT: begin
        tmr_clr = 1'b1;
        if (!level) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (level) begin
          state_nxt = ST_HELD;
          press_nxt = 1'b1;
        end
      end
      ST_HELD: begin
        if (!level) begin
          state_nxt = ST_IDLE;
          rel_nxt   = 1'b1;
          tmr_clr   = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            state_nxt = ST_LONG;
            long_nxt  = 1'b1;
          end
        end
      end
      default: begin // ST_LONG
        if (!level) begin
          state_nxt = ST_IDLE;
          rel_nxt   = 1'b1;
          tmr_clr   = 1'b1;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          tmr_en   = 1'b1;
          tmr_term = RP_TERM;
          rep_nxt  = tmr_done;
`endif
        end
      end
    endcase
  end

  // State, registered event pulses, held level and press counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_LOCKOUT;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_nxt;
      press         <= press_nxt;
      release_pulse <= rel_nxt;
      long_press    <= long_nxt;
      repeat_pulse  <= rep_nxt;
      held          <= (state_nxt == ST_HELD) || (state_nxt == ST_LONG);
      if (press_nxt) press_count <= press_count + PRESS_COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point,
// so each sample shows the result of the edge that just consumed the prior input.
module tb_button_event_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       level;
  logic       press, release_pulse, long_press, repeat_pulse, held;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  button_event_gen #(
    .LONG_PRESS_CYCLES (8),
    .REPEAT_CYCLES     (4),
    .CNT_W             (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_count   (press_count)
  );

  always #5 clock = ~clock;

  // {press, release, long_press, repeat_pulse, held}
  function automatic logic [4:0] evs();
    return {press, release_pulse, long_press, repeat_pulse, held};
  endfunction

  task automatic cyc(input logic lv);
    level = lv;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] exp;
    reset = 1'b1;
    level = 1'b1;
    #2;
    // Reset with the button already down.
    repeat (3) cyc(1'b1);
    chk("reset_evs", 32'(evs()), 32'h0);
    chk("reset_cnt", 32'(press_count), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("lockout_evs", 32'(evs()), 32'h0);
      chk("lockout_cnt", 32'(press_count), 32'h0);
    end
    cyc(1'b0);
    chk("lockout_exit", 32'(evs()), 32'h0);

    // Short press: 3 cycles high.
    cyc(1'b1);
    chk("short_press", 32'(evs()), 32'b10001);
    chk("short_cnt", 32'(press_count), 32'd1);
    cyc(1'b1);
    chk("short_held2", 32'(evs()), 32'b00001);
    cyc(1'b1);
    chk("short_held3", 32'(evs()), 32'b00001);
    cyc(1'b0);
    chk("short_release", 32'(evs()), 32'b01000);
    cyc(1'b0);
    chk("short_quiet", 32'(evs()), 32'b00000);

    // Long hold: long_press at +8, repeats at +12,+16,+20 when enabled.
    for (int i = 0; i <= 20; i++) begin
      cyc(1'b1);
      exp = {i == 0, 1'b0, i == 8, AUTOREP && (i > 8) && ((i - 8) % 4 == 0), 1'b1};
      chk($sformatf("long_hold_%0d", i), 32'(evs()), 32'(exp));
    end
    chk("long_cnt", 32'(press_count), 32'd2);
    cyc(1'b0);
    chk("long_release", 32'(evs()), 32'b01000);

    // Drop exactly when long_press would fire.
    cyc(1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1);
      exp = {i == 0, 1'b0, 1'b0, 1'b0, 1'b1};
      chk($sformatf("edge_hold_%0d", i), 32'(evs()), 32'(exp));
    end
    cyc(1'b0);
    chk("edge_release", 32'(evs()), 32'b01000);
    cyc(1'b0);
    chk("edge_after", 32'(evs()), 32'b00000);
    chk("edge_cnt", 32'(press_count), 32'd3);

    // Counter wrap from a fresh reset.
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    cyc(1'b0);
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    chk("wrap_256", 32'(press_count), 32'd0);
    cyc(1'b1);
    chk("wrap_257", 32'(press_count), 32'd1);
    cyc(1'b0);

    // Reset in the middle of LONG.
    for (int i = 0; i < 10; i++) cyc(1'b1);
    chk("mid_long_held", 32'(evs()), 32'b00001);
    reset = 1'b1;
    cyc(1'b1);
    chk("midrst_evs", 32'(evs()), 32'h0);
    chk("midrst_cnt", 32'(press_count), 32'h0);
    reset = 1'b0;
    cyc(1'b1);
    chk("midrst_lock", 32'(evs()), 32'h0);
    cyc(1'b0);
    chk("midrst_norel", 32'(evs()), 32'h0);
    cyc(1'b1);
    chk("midrst_press", 32'(evs()), 32'b10001);
    cyc(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
